// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the 8-bit ALU datapath and its
// issue controller.
//   op_code_e : 3-bit ALU operation encoding
//   cmd_t     : one buffered request {op, a, b, tag}
//   pack_cmd  : builds a cmd_t from raw request fields
package alu_pkg;

    localparam int ALU_OPND_W    = 8;
    localparam int ALU_RES_W     = 16;
    localparam int ALU_OP_W      = 3;
    // Widest request tag the command entry can carry; the controller's TAG_W
    // must not exceed this.
    localparam int CMD_TAG_MAX_W = 16;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        MUL  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        AND  = 3'd5,
        NAND = 3'd6,
        NOR  = 3'd7
    } op_code_e;

    typedef struct packed {
        op_code_e                 op;
        logic [ALU_OPND_W-1:0]    a;
        logic [ALU_OPND_W-1:0]    b;
        logic [CMD_TAG_MAX_W-1:0] tag;
    } cmd_t;

    function automatic cmd_t pack_cmd(
        input logic [ALU_OP_W-1:0]      op,
        input logic [ALU_OPND_W-1:0]    a,
        input logic [ALU_OPND_W-1:0]    b,
        input logic [CMD_TAG_MAX_W-1:0] tag
    );
        cmd_t c;
        c.op  = op_code_e'(op);
        c.a   = a;
        c.b   = b;
        c.tag = tag;
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; ignored while full
//   pop, dout     : read request and head data (dout valid while !empty);
//                   pop is ignored while empty
//   full, empty   : occupancy flags derived from count
//   count         : number of stored entries, 0..DEPTH
// Push and pop in the same cycle are both honoured; a pop does not make room
// for a same-cycle push when the FIFO is full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command/response front end for the 8-bit ALU.
// Requests are buffered in a command FIFO and issued to the ALU one per cycle
// through registered alu_op_code/alu_a/alu_b. The ALU registers its result
// one cycle after issue; the controller captures it one cycle later and
// returns it with the originating tag through a response FIFO.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : request handshake
//   cmd_op, cmd_a, cmd_b, cmd_tag    : request payload
//   alu_op_code, alu_a, alu_b        : registered ALU inputs
//   alu_result                       : registered ALU output
//   rsp_valid/rsp_ready              : response handshake
//   rsp_result, rsp_tag              : response payload
//   busy                             : work queued, in flight or unread
//
// Handshakes: a transfer happens at a rising edge where valid && ready are
// both high. The source holds its payload stable while valid is high and the
// transfer has not happened; ready never depends on valid in this block.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ALU_OP_W-1:0]   cmd_op,
    input  logic [ALU_OPND_W-1:0] cmd_a,
    input  logic [ALU_OPND_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]      cmd_tag,
    output logic [ALU_OP_W-1:0]   alu_op_code,
    output logic [ALU_OPND_W-1:0] alu_a,
    output logic [ALU_OPND_W-1:0] alu_b,
    input  logic [ALU_RES_W-1:0]  alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ALU_RES_W-1:0]  rsp_result,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  busy
);

    localparam int CMD_CNT_W = $clog2(CMD_DEPTH) + 1;
    localparam int RSP_CNT_W = $clog2(RES_DEPTH) + 1;
    localparam int RSP_W     = ALU_RES_W + TAG_W;

    // Command side
    cmd_t                 cmd_din;
    cmd_t                 cmd_head;
    logic                 cmd_push;
    logic                 cmd_full;
    logic                 cmd_empty;
    logic [CMD_CNT_W-1:0] cmd_count;

    // Issue pipeline: v1/t1 mark the op whose operands sit on the ALU inputs,
    // v2/t2 mark the op whose result sits in the ALU result register.
    logic                 issue;
    logic                 v1;
    logic                 v2;
    logic [TAG_W-1:0]     t1;
    logic [TAG_W-1:0]     t2;
    logic [RSP_CNT_W:0]   credit_used;

    // Response side
    logic                 rsp_push;
    logic                 rsp_pop;
    logic                 rsp_full;
    logic                 rsp_empty;
    logic [RSP_CNT_W-1:0] rsp_count;
    logic [RSP_W-1:0]     rsp_din;
    logic [RSP_W-1:0]     rsp_dout;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_din   = pack_cmd(cmd_op, cmd_a, cmd_b, CMD_TAG_MAX_W'(cmd_tag));

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .din   (cmd_din),
        .pop   (issue),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    // ------------------------------------------------------------------
    // Credit check: every op in flight already owns a response slot, so an
    // op may only issue when held + in-flight responses leave a free slot.
    // Only current-cycle occupancy counts; a same-cycle response pop does
    // not lend a slot, which keeps this path free of rsp_ready.
    // ------------------------------------------------------------------
    always_comb begin
        credit_used = {1'b0, rsp_count}
                    + {{RSP_CNT_W{1'b0}}, v1}
                    + {{RSP_CNT_W{1'b0}}, v2};
        issue       = !cmd_empty && (credit_used < (RSP_CNT_W + 1)'(RES_DEPTH));
    end

    // ------------------------------------------------------------------
    // ALU input registers and valid/tag pipeline. The ALU inputs hold their
    // last value when nothing issues; v1 = 0 marks them as stale.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_code <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            t1          <= '0;
            t2          <= '0;
        end else begin
            v1 <= issue;
            v2 <= v1;
            t2 <= t1;
            if (issue) begin
                alu_op_code <= cmd_head.op;
                alu_a       <= cmd_head.a;
                alu_b       <= cmd_head.b;
                t1          <= cmd_head.tag[TAG_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO. alu_result is captured only when v2 marks it as the
    // result of an issued op, so stale ALU output after reset never escapes.
    // ------------------------------------------------------------------
    assign rsp_push = v2;
    assign rsp_din  = {alu_result, t2};
    assign rsp_pop  = rsp_valid && rsp_ready;

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RES_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .din   (rsp_din),
        .pop   (rsp_pop),
        .dout  (rsp_dout),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign rsp_valid             = !rsp_empty;
    assign {rsp_result, rsp_tag} = rsp_dout;

    assign busy = !cmd_empty | v1 | v2 | !rsp_empty;

    // Signals kept for observability but not needed by the datapath.
    logic unused_state;
    assign unused_state = ^{cmd_count, rsp_full, cmd_head.tag};

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int CMD_DEPTH = 4;
    localparam int RES_DEPTH = 4;
    localparam int TAG_W     = 4;
    localparam int EXP_W     = ALU_RES_W + TAG_W;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ALU_OP_W-1:0]   cmd_op;
    logic [ALU_OPND_W-1:0] cmd_a;
    logic [ALU_OPND_W-1:0] cmd_b;
    logic [TAG_W-1:0]      cmd_tag;
    logic [ALU_OP_W-1:0]   alu_op_code;
    logic [ALU_OPND_W-1:0] alu_a;
    logic [ALU_OPND_W-1:0] alu_b;
    logic [ALU_RES_W-1:0]  alu_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ALU_RES_W-1:0]  rsp_result;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  busy;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .CMD_DEPTH (CMD_DEPTH),
        .RES_DEPTH (RES_DEPTH),
        .TAG_W     (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_tag     (cmd_tag),
        .alu_op_code (alu_op_code),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .busy        (busy)
    );

    // Reference ALU arithmetic: 16-bit context, zero-extended operands.
    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [15:0] x;
        logic [15:0] y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (op_code_e'(op))
            ADD:     return x + y;
            SUB:     return x - y;
            MUL:     return x * y;
            OR:      return x | y;
            XOR:     return x ^ y;
            AND:     return x & y;
            NAND:    return ~(x & y);
            default: return ~(x | y);
        endcase
    endfunction

    // Environment ALU: registers its result one edge after the inputs change.
    logic [15:0] alu_res_q = 16'h0;
    always @(posedge clk) alu_res_q <= ref_alu(alu_op_code, alu_a, alu_b);
    assign alu_result = alu_res_q;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]     exp_q[$];
    logic [ALU_RES_W-1:0] got_res_q[$];
    logic [TAG_W-1:0]     got_tag_q[$];
    int                   hs_cyc_q[$];
    int                   tests = 0;
    int                   fails = 0;
    int                   cyc = 0;
    int                   rsp_mode = 1;  // 0: hold low, 1: hold high, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // rsp_ready driver, owned by this process only.
    always @(posedge clk) begin
        #1;
        case (rsp_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Compare process: sampled on the falling edge, between active edges.
    // Anything accepted and not yet returned must keep busy high; responses
    // must come back in acceptance order with the model's result.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            check("busy", busy, exp_q.size() != 0);
            if (dut.rsp_push) begin
                check("rsp_no_overflow", dut.rsp_full, 1'b0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", rsp_result, e[EXP_W-1:TAG_W]);
                    check("rsp_tag", rsp_tag, e[TAG_W-1:0]);
                end
                got_res_q.push_back(rsp_result);
                got_tag_q.push_back(rsp_tag);
                hs_cyc_q.push_back(cyc);
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({ref_alu(cmd_op, cmd_a, cmd_b), cmd_tag});
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one request and holds it until accepted (bounded wait).
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [TAG_W-1:0] tag);
        bit accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        for (int k = 0; k < 300 && !accepted; k++) begin
            @(negedge clk);
            accepted = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!accepted) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) tick(1);
        check("drain_empty", exp_q.size(), 0);
        tick(2);
    endtask

    task automatic clear_got();
        got_res_q.delete();
        got_tag_q.delete();
        hs_cyc_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [15:0] ops_exp [8] = '{16'h0100, 16'h00FE, 16'h00FF, 16'h00FF,
                                 16'h00FE, 16'h0001, 16'hFFFE, 16'hFF00};
    logic [15:0] b2b_exp [3] = '{16'hFFFB, 16'hFE01, 16'hFF0F};

    initial begin
        int first;
        int acc;
        int unstable;
        logic [18:0] snap;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b1;
        rsp_mode  = 1;
        tick(3);
        rst = 1'b0;

        // Reset values
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_alu_op", alu_op_code, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);

        // Pin the model with hand-computed values
        check("model_add", ref_alu(3'd0, 8'd200, 8'd100), 16'h012C);
        check("model_sub", ref_alu(3'd1, 8'd5, 8'd10), 16'hFFFB);
        check("model_mul", ref_alu(3'd2, 8'd255, 8'd255), 16'hFE01);
        check("model_nand", ref_alu(3'd6, 8'hF0, 8'hFF), 16'hFF0F);
        check("model_xor", ref_alu(3'd4, 8'hAA, 8'h0F), 16'h00A5);
        check("model_nor", ref_alu(3'd7, 8'hFF, 8'h01), 16'hFF00);

        // ADD with minimum latency: rsp_valid rises after the third edge
        clear_got();
        send_cmd(3'd0, 8'd200, 8'd100, 4'd1);
        first = -1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            if (rsp_valid && first < 0) first = k;
        end
        check("add_latency", first, 3);
        drain();
        check("add_count", got_res_q.size(), 1);
        if (got_res_q.size() >= 1) begin
            check("add_result", got_res_q[0], 16'h012C);
            check("add_tag", got_tag_q[0], 4'd1);
        end

        // Back-to-back SUB, MUL, NAND at full rate
        clear_got();
        send_cmd(3'd1, 8'd5, 8'd10, 4'd2);
        send_cmd(3'd2, 8'd255, 8'd255, 4'd3);
        send_cmd(3'd6, 8'hF0, 8'hFF, 4'd4);
        drain();
        check("b2b_count", got_res_q.size(), 3);
        for (int i = 0; i < 3 && i < got_res_q.size(); i++) begin
            check("b2b_result", got_res_q[i], b2b_exp[i]);
            check("b2b_tag", got_tag_q[i], 32'(i + 2));
        end
        for (int i = 1; i < 3 && i < hs_cyc_q.size(); i++) begin
            check("b2b_one_per_cycle", hs_cyc_q[i] - hs_cyc_q[i-1], 1);
        end

        // Backpressure: 8 fit (RES_DEPTH issued + CMD_DEPTH queued), 9th waits
        rsp_mode = 0;
        tick(2);
        clear_got();
        for (int i = 0; i < 8; i++) begin
            send_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'(i));
        end
        tick(3);
        check("full_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_a     = 8'h55;
        cmd_b     = 8'h33;
        cmd_tag   = 4'd9;
        snap      = {alu_op_code, alu_a, alu_b};
        acc       = 0;
        unstable  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cmd_ready) acc++;
            if ({alu_op_code, alu_a, alu_b} != snap) unstable++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("hold_no_accept", acc, 0);
        check("hold_alu_stable", unstable, 0);
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_busy", busy, 1);
        check("hold_got_none", got_res_q.size(), 0);
        rsp_mode = 1;
        drain();
        check("release_count", got_res_q.size(), 8);
        for (int i = 0; i < 8 && i < got_tag_q.size(); i++) begin
            check("release_tag_order", got_tag_q[i], 32'(i));
        end

        // Reset with work queued, in flight and held
        rsp_mode = 0;
        tick(2);
        send_cmd(3'd0, 8'd1, 8'd2, 4'd10);
        send_cmd(3'd0, 8'd3, 8'd4, 4'd11);
        tick(5);
        for (int i = 0; i < 5; i++) send_cmd(3'd2, 8'(i + 7), 8'd9, 4'(12 + i));
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_cmd_ready", cmd_ready, 1);
        rsp_mode = 1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (rsp_valid) acc++;
        end
        check("post_reset_no_stale", acc, 0);
        clear_got();
        send_cmd(3'd4, 8'hAA, 8'h0F, 4'd5);
        drain();
        check("xor_count", got_res_q.size(), 1);
        if (got_res_q.size() >= 1) check("xor_result", got_res_q[0], 16'h00A5);

        // All op codes with a=FF, b=01
        clear_got();
        for (int op = 0; op < 8; op++) send_cmd(3'(op), 8'hFF, 8'h01, 4'(op));
        drain();
        check("allops_count", got_res_q.size(), 8);
        for (int i = 0; i < 8 && i < got_res_q.size(); i++) begin
            check("allops_result", got_res_q[i], ops_exp[i]);
        end

        // Random traffic with random response backpressure
        rsp_mode = 2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick(1);
            end else begin
                send_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'($urandom));
            end
        end
        rsp_mode = 1;
        tick(1);
        drain();
        check("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
